// File: rtl/brs_uart_tx.sv
// Byte UART transmitter (start, 8 data LSB-first, optional even parity via BRS_UART_PARITY_EN, stop) fed by a small FIFO.
// Latency: push at edge N into an idle block gives start bit from N+1; backpressure: in_ready = !full, no pop bypass.

module brs_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  // One extra pointer bit separates full from empty when the low bits match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

module brs_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic                         tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          baud_last;
  logic          load;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;
`ifdef BRS_UART_PARITY_EN
  logic          par_bit;
`endif

  assign in_ready  = !fifo_full;
  assign baud_last = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  // A new frame starts from IDLE or straight out of the last stop-bit cycle.
  assign load      = !fifo_empty && ((state == S_IDLE) || (state == S_STOP && baud_last));
  assign busy      = (state != S_IDLE) || (fifo_level != '0);

  brs_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata (in_data),
    .pop   (load),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef BRS_UART_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (load) begin
            state    <= S_START;
            tx       <= 1'b0;
            baud_cnt <= '0;
            shreg    <= fifo_rdata;
`ifdef BRS_UART_PARITY_EN
            par_bit  <= ^fifo_rdata;
`endif
          end
        end
        S_START: begin
          if (baud_last) begin
            state    <= S_DATA;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shreg[0];
            shreg    <= shreg >> 1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
`ifdef BRS_UART_PARITY_EN
              state   <= S_PARITY;
              tx      <= par_bit;
`else
              state   <= S_STOP;
              tx      <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef BRS_UART_PARITY_EN
        S_PARITY: begin
          if (baud_last) begin
            state    <= S_STOP;
            tx       <= 1'b1;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (load) begin
              state   <= S_START;
              tx      <= 1'b0;
              shreg   <= fifo_rdata;
`ifdef BRS_UART_PARITY_EN
              par_bit <= ^fifo_rdata;
`endif
            end else begin
              state   <= S_IDLE;
              tx      <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_brs_uart_tx.sv
// Bench for brs_uart_tx: frame-level reference model (byte queue + frame timer) checked every cycle.
module tb_brs_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef BRS_UART_PARITY_EN
  localparam int L = 11;
`else
  localparam int L = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: queued bytes, the byte on the line, cycles left in its frame.
  logic [7:0] q[$];
  logic [7:0] cur = 8'h00;
  int         rem = 0;

  brs_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic exp_tx();
    int idx;
    if (rem == 0) return 1'b1;
    idx = (L * CPB - rem) / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return cur[idx-1];
    if (L == 11 && idx == 9) return ^cur;
    return 1'b1;
  endfunction

  function automatic logic [5:0] exp_vec();
    return {exp_tx(), (rem != 0 || q.size() != 0), (q.size() < DEPTH), 3'(q.size())};
  endfunction

  // Drive one cycle of stimulus and advance the model across the edge.
  task automatic tick(input logic v, input logic [7:0] d);
    bit ok;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    cyc++;
    ok = v && (q.size() < DEPTH);
    if (rem > 0) rem--;
    if (rem == 0 && q.size() > 0) begin
      cur = q.pop_front();
      rem = L * CPB;
    end
    if (ok) q.push_back(d);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({tx, busy, in_ready, fifo_level} !== 6'b101000)
      $display("FAIL reset_state got=%b exp=%b", {tx, busy, in_ready, fifo_level}, 6'b101000);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick(1'b0, 8'h00);
      n_checks++;
      if ({tx, busy, in_ready, fifo_level} !== 6'b101000)
        $display("FAIL idle_after_reset cyc=%0d got=%b exp=%b", cyc, {tx, busy, in_ready, fifo_level}, 6'b101000);
      else n_pass++;
    end
  endtask

  task automatic test_single(input logic [7:0] d, input logic exp_par);
    int fall = -1;
    tick(1'b1, d);
    for (int k = 1; k <= L * CPB + 4; k++) begin
      tick(1'b0, 8'h00);
      n_checks++;
      if ({tx, busy, in_ready, fifo_level} !== exp_vec())
        $display("FAIL single_%h cyc=%0d got=%b exp=%b", d, cyc, {tx, busy, in_ready, fifo_level}, exp_vec());
      else n_pass++;
      if (k == 1 + 9 * CPB + 1) begin
        n_checks++;
`ifdef BRS_UART_PARITY_EN
        if (tx !== exp_par) $display("FAIL parity_%h got=%b exp=%b", d, tx, exp_par);
`else
        if (tx !== 1'b1) $display("FAIL stop_%h got=%b exp=%b", d, tx, 1'b1);
`endif
        else n_pass++;
      end
      if (fall < 0 && busy === 1'b0) fall = k;
    end
    n_checks++;
    if (fall !== L * CPB + 1) $display("FAIL busy_fall_%h got=%0d exp=%0d", d, fall, L * CPB + 1);
    else n_pass++;
  endtask

  task automatic test_burst();
    logic [7:0] bytes [6];
    int peak = 0;
    int idle_at = -1;
    bytes = '{8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (in_ready !== (q.size() < DEPTH))
        $display("FAIL burst_ready_%0d got=%b exp=%b", i, in_ready, q.size() < DEPTH);
      else n_pass++;
      tick(1'b1, bytes[i]);
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    n_checks++;
    if (peak !== DEPTH) $display("FAIL burst_peak got=%0d exp=%0d", peak, DEPTH);
    else n_pass++;
    for (int k = 0; k < 6 * L * CPB; k++) begin
      tick(1'b0, 8'h00);
      n_checks++;
      if ({tx, busy, in_ready, fifo_level} !== exp_vec())
        $display("FAIL burst_frame cyc=%0d got=%b exp=%b", cyc, {tx, busy, in_ready, fifo_level}, exp_vec());
      else n_pass++;
      if (idle_at < 0 && busy === 1'b0) idle_at = k;
    end
    // Five bytes accepted and sent gap-free: idle exactly 5 frames after the first pop.
    n_checks++;
    if (idle_at !== 5 * L * CPB - 5) $display("FAIL burst_no_gap got=%0d exp=%0d", idle_at, 5 * L * CPB - 5);
    else n_pass++;
  endtask

  task automatic test_push_pop();
    int guard = 0;
    for (int i = 0; i < 4; i++) tick(1'b1, 8'h10 + 8'(i));
    while (!(rem == 1 && q.size() == 3) && guard < 4 * L * CPB) begin
      tick(1'b0, 8'h00);
      guard++;
    end
    n_checks++;
    if (guard >= 4 * L * CPB) $display("FAIL push_pop_setup timeout got=%0d exp=<%0d", guard, 4 * L * CPB);
    else n_pass++;
    tick(1'b1, 8'hFF);
    n_checks++;
    if ({tx, fifo_level} !== {1'b0, 3'd3})
      $display("FAIL push_pop_level got=%b exp=%b", {tx, fifo_level}, {1'b0, 3'd3});
    else n_pass++;
    for (int k = 0; k < 5 * L * CPB; k++) begin
      tick(1'b0, 8'h00);
      n_checks++;
      if ({tx, busy, in_ready, fifo_level} !== exp_vec())
        $display("FAIL push_pop_drain cyc=%0d got=%b exp=%b", cyc, {tx, busy, in_ready, fifo_level}, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    for (int i = 0; i < 3; i++) tick(1'b1, 8'hC3 + 8'(i));
    // Middle of data bit 3 (frame bit index 4).
    while (rem != L * CPB - 4 * CPB - 1 && guard < 2 * L * CPB) begin
      tick(1'b0, 8'h00);
      guard++;
    end
    n_checks++;
    if (tx !== cur[3] || q.size() != 2) $display("FAIL reset_mid_setup got=%b exp=%b", tx, cur[3]);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    rem = 0;
    n_checks++;
    if ({tx, busy, in_ready, fifo_level} !== 6'b101000)
      $display("FAIL reset_mid got=%b exp=%b", {tx, busy, in_ready, fifo_level}, 6'b101000);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3 * L * CPB; k++) begin
      tick(1'b0, 8'h00);
      n_checks++;
      if ({tx, busy, in_ready, fifo_level} !== 6'b101000)
        $display("FAIL after_reset_mid cyc=%0d got=%b exp=%b", cyc, {tx, busy, in_ready, fifo_level}, 6'b101000);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500 + 6 * L * CPB; k++) begin
      if (k < 1500) tick($urandom_range(0, 19) == 0 || (k % 300 < 8), 8'($urandom));
      else tick(1'b0, 8'h00);
      n_checks++;
      if ({tx, busy, in_ready, fifo_level} !== exp_vec())
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {tx, busy, in_ready, fifo_level}, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL random_drain got=%b exp=%b", busy, 1'b0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single(8'hA5, 1'b0);
    test_single(8'h07, 1'b1);
    test_burst();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
